// File: rtl/sample_dma_pkg.sv
// Register map, FSM state encoding and STATUS layout shared by sample_dma and its bench.
// No logic; the helper packs STATUS fields into the 32-bit register image.
package sample_dma_pkg;

  localparam logic [4:0] SDMA_CTRL   = 5'h00;
  localparam logic [4:0] SDMA_START  = 5'h04;
  localparam logic [4:0] SDMA_END    = 5'h08;
  localparam logic [4:0] SDMA_PTR    = 5'h0C;
  localparam logic [4:0] SDMA_STATUS = 5'h10;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CIRCULAR = 1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_WRAPPED   = 2;
  localparam int STAT_COUNT_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } sdma_state_t;

  function automatic logic [31:0] sdma_status(input logic st_busy, input logic st_done,
                                              input logic st_wrapped, input logic [15:0] st_count);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]               = st_busy;
    s[STAT_DONE]               = st_done;
    s[STAT_WRAPPED]            = st_wrapped;
    s[STAT_COUNT_LSB +: 16]    = st_count;
    return s;
  endfunction

endpackage

// File: rtl/sample_dma.sv
// Streams sample-FIFO words into SDRAM writes over [START,END); ring wrap only with SAMPLE_DMA_CIRCULAR_EN.
// fifo_rd to wvalid is 2 cycles, 3 cycles/word minimum; write held until wready, empty FIFO stalls losslessly.
module sample_dma
  import sample_dma_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   fifo_rd_data,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic [AW-1:0] awaddr,
  output logic [15:0]   wdata,
  output logic          wvalid,
  input  logic          wready,
  input  logic [4:0]    cfg_waddr,
  input  logic [31:0]   cfg_wdata,
  input  logic          cfg_wvalid,
  input  logic [4:0]    cfg_araddr,
  input  logic          cfg_arvalid,
  output logic [31:0]   cfg_rdata,
  output logic          cfg_rvalid
);

`ifdef SAMPLE_DMA_CIRCULAR_EN
  localparam logic CIRC_EN = 1'b1;
`else
  localparam logic CIRC_EN = 1'b0;
`endif

  sdma_state_t   state, state_nxt;
  logic          enable;
  logic          circular;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_inc;
  logic          done;
  logic          wrapped;
  logic [15:0]   count;
  logic          busy;
  logic          win_empty;
  logic          hit_end;
  logic          start_req;
  logic [31:0]   rd_mux;
  logic          unused_cfg;

  assign busy      = (state == S_FETCH) || (state == S_LATCH) || (state == S_WRITE);
  assign win_empty = (end_addr <= start_addr);
  assign ptr_inc   = ptr + AW'(1);
  assign hit_end   = (ptr_inc == end_addr);
  assign start_req = cfg_wvalid && (cfg_waddr == SDMA_CTRL) && cfg_wdata[CTRL_ENABLE] && !busy;
  assign unused_cfg = ^cfg_wdata[31:AW];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_req) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (win_empty)        state_nxt = S_DONE;
        else if (!enable)     state_nxt = S_IDLE;
        else if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: state_nxt = S_WRITE;
      S_WRITE: begin
        if (wready) begin
          if (hit_end && !circular) state_nxt = S_DONE;
          else if (!enable)         state_nxt = S_IDLE;
          else                      state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Register file and write datapath; FSM-driven updates come after CPU writes so they win.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable     <= 1'b0;
      circular   <= 1'b0;
      start_addr <= '0;
      end_addr   <= '0;
      ptr        <= '0;
      done       <= 1'b0;
      wrapped    <= 1'b0;
      count      <= '0;
      awaddr     <= '0;
      wdata      <= '0;
      wvalid     <= 1'b0;
    end else begin
      if (cfg_wvalid) begin
        case (cfg_waddr)
          SDMA_CTRL: begin
            enable   <= cfg_wdata[CTRL_ENABLE];
            circular <= CIRC_EN & cfg_wdata[CTRL_CIRCULAR];
            if (start_req) begin
              ptr     <= start_addr;
              done    <= 1'b0;
              wrapped <= 1'b0;
              count   <= '0;
            end
          end
          SDMA_START: if (!busy) start_addr <= cfg_wdata[AW-1:0];
          SDMA_END:   if (!busy) end_addr   <= cfg_wdata[AW-1:0];
          default: ;
        endcase
      end

      case (state)
        S_FETCH: begin
          if (win_empty) begin
            done   <= 1'b1;
            enable <= 1'b0;
          end
        end
        S_LATCH: begin
          wdata  <= fifo_rd_data;
          awaddr <= ptr;
          wvalid <= 1'b1;
        end
        S_WRITE: begin
          if (wready) begin
            wvalid <= 1'b0;
            if (count != 16'hFFFF) count <= count + 16'd1;
            if (hit_end && circular) begin
              ptr     <= start_addr;
              wrapped <= 1'b1;
            end else begin
              ptr <= ptr_inc;
              if (hit_end) begin
                done   <= 1'b1;
                enable <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_araddr)
      SDMA_CTRL:   rd_mux = {30'd0, circular, enable};
      SDMA_START:  rd_mux = 32'(start_addr);
      SDMA_END:    rd_mux = 32'(end_addr);
      SDMA_PTR:    rd_mux = 32'(ptr);
      SDMA_STATUS: rd_mux = sdma_status(busy, done, wrapped, count);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= cfg_arvalid;
      if (cfg_arvalid) cfg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sample_dma.sv
// Bench for sample_dma: FIFO/SDRAM models plus a word-list reference of expected writes.
module tb_sample_dma;
  import sample_dma_pkg::*;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [AW-1:0] awaddr;
  logic [15:0]   wdata;
  logic          wvalid;
  logic          wready;
  logic [4:0]    cfg_waddr;
  logic [31:0]   cfg_wdata;
  logic          cfg_wvalid;
  logic [4:0]    cfg_araddr;
  logic          cfg_arvalid;
  logic [31:0]   cfg_rdata;
  logic          cfg_rvalid;

  always #5 clk = ~clk;

  sample_dma #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .awaddr(awaddr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata), .cfg_wvalid(cfg_wvalid),
    .cfg_araddr(cfg_araddr), .cfg_arvalid(cfg_arvalid),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Sample FIFO model: read data appears the cycle after fifo_rd.
  logic [15:0] fmem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rd_data <= fmem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    fmem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // SDRAM side: wready is either a fixed level or random.
  logic wr_mode   = 1'b0;
  logic wready_fix = 1'b0;
  initial begin
    wready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      wready = wr_mode ? 1'($urandom_range(0, 1)) : wready_fix;
    end
  end

  logic [AW-1:0] acc_addr [$];
  logic [15:0]   acc_data [$];
  int            rd_cnt = 0;
  int            stab_err = 0;
  int            rd_empty_err = 0;
  logic          hold_pend = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [15:0]   hold_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && !(wvalid && awaddr == hold_addr && wdata == hold_data)) stab_err++;
      hold_pend = wvalid && !wready;
      hold_addr = awaddr;
      hold_data = wdata;
      if (wvalid && wready) begin
        acc_addr.push_back(awaddr);
        acc_data.push_back(wdata);
      end
      if (fifo_rd) rd_cnt++;
      if (fifo_rd && fifo_empty) rd_empty_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_waddr = a; cfg_wdata = d; cfg_wvalid = 1'b1;
    tick(1);
    cfg_wvalid = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d, output logic rv);
    cfg_araddr = a; cfg_arvalid = 1'b1;
    tick(1);
    cfg_arvalid = 1'b0;
    rv = cfg_rvalid;
    d  = cfg_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic rv;
    cfg_read(a, d, rv);
    chk(tag, d, exp);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    logic [31:0] d;
    logic rv;
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      cfg_read(SDMA_STATUS, d, rv);
      if (!d[STAT_BUSY]) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (acc_addr.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(acc_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_wvalid(input int budget, input string tag);
    int k;
    k = 0;
    while (!wvalid && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(wvalid), 32'd1);
  endtask

  task automatic acc_clear();
    acc_addr.delete();
    acc_data.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL tb_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]   d;
    logic          rv;
    int            rd0;
    logic [AW-1:0] s;
    int            len, n1, extra, total;
    logic [15:0]   exp_w [16];

    rst = 1'b1;
    cfg_waddr = '0; cfg_wdata = '0; cfg_wvalid = 1'b0;
    cfg_araddr = '0; cfg_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_awaddr", 32'(awaddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    rd_chk("rst_ctrl", SDMA_CTRL, 32'd0);
    rd_chk("rst_status", SDMA_STATUS, 32'd0);
    rd_chk("rst_ptr", SDMA_PTR, 32'd0);
    rd_chk("unmapped", 5'h14, 32'd0);

    // Linear transfer of four words with wready high
    cfg_write(SDMA_START, 32'h100);
    cfg_write(SDMA_END, 32'h104);
    for (int i = 0; i < 4; i++) push(16'hA001 + 16'(i));
    acc_clear();
    wready_fix = 1'b1;
    tick(1);
    cfg_write(SDMA_CTRL, 32'h1);
    chk("t0_fifo_rd", 32'(fifo_rd), 32'd1);
    tick(1);
    chk("t1_wvalid_low", 32'(wvalid), 32'd0);
    tick(1);
    chk("t2_wvalid", 32'(wvalid), 32'd1);
    chk("t2_awaddr", 32'(awaddr), 32'h100);
    chk("t2_wdata", 32'(wdata), 32'hA001);
    wait_idle(100, "lin_wait");
    chk("lin_nwr", 32'(acc_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
      chk("lin_addr", 32'(acc_addr[i]), 32'h100 + 32'(i));
      chk("lin_data", 32'(acc_data[i]), 32'hA001 + 32'(i));
    end
    rd_chk("lin_status", SDMA_STATUS, 32'h0004_0002);
    rd_chk("lin_ptr", SDMA_PTR, 32'h104);
    rd_chk("lin_ctrl_selfclr", SDMA_CTRL, 32'd0);

    // Second word held off by wready for five cycles
    cfg_write(SDMA_START, 32'h200);
    cfg_write(SDMA_END, 32'h210);
    push(16'hB001);
    push(16'hB002);
    acc_clear();
    cfg_write(SDMA_CTRL, 32'h1);
    wait_acc(1, 20, "stall_first");
    wready_fix = 1'b0;
    wait_wvalid(20, "stall_wvalid");
    tick(5);
    chk("stall_wvalid_hold", 32'(wvalid), 32'd1);
    chk("stall_awaddr", 32'(awaddr), 32'h201);
    chk("stall_wdata", 32'(wdata), 32'hB002);
    chk("stall_not_acc", 32'(acc_addr.size()), 32'd1);
    wready_fix = 1'b1;
    tick(4);
    chk("stall_acc_once", 32'(acc_addr.size()), 32'd2);
    if (acc_addr.size() >= 2) chk("stall_acc_addr", 32'(acc_addr[1]), 32'h201);
    rd_chk("stall_status", SDMA_STATUS, 32'h0002_0001);
    cfg_write(SDMA_END, 32'h5);
    rd_chk("end_locked_busy", SDMA_END, 32'h210);
    cfg_write(SDMA_CTRL, 32'h0);
    tick(2);
    rd_chk("stall_stopped", SDMA_STATUS, 32'h0002_0000);

    // Stop while a write is waiting on wready
    cfg_write(SDMA_START, 32'h300);
    cfg_write(SDMA_END, 32'h310);
    wready_fix = 1'b0;
    push(16'hC001);
    acc_clear();
    tick(1);
    cfg_write(SDMA_CTRL, 32'h1);
    wait_wvalid(20, "stop_wvalid");
    push(16'hC002);
    cfg_write(SDMA_CTRL, 32'h0);
    tick(3);
    chk("stop_wvalid_held", 32'(wvalid), 32'd1);
    wready_fix = 1'b1;
    tick(4);
    chk("stop_nwr", 32'(acc_addr.size()), 32'd1);
    chk("stop_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    rd_chk("stop_status", SDMA_STATUS, 32'h0001_0000);
    rd_chk("stop_ptr", SDMA_PTR, 32'h301);
    wr_ptr = rd_ptr;

    // Simultaneous register write and read returns the old value
    cfg_waddr = SDMA_START; cfg_wdata = 32'h55; cfg_wvalid = 1'b1;
    cfg_araddr = SDMA_START; cfg_arvalid = 1'b1;
    tick(1);
    cfg_wvalid = 1'b0; cfg_arvalid = 1'b0;
    chk("rw_same_old", cfg_rdata, 32'h300);
    rd_chk("rw_same_new", SDMA_START, 32'h55);

    // Circular bit: stored only when the ring option is built in
    cfg_write(SDMA_CTRL, 32'h2);
`ifdef SAMPLE_DMA_CIRCULAR_EN
    rd_chk("ctrl_circ_bit", SDMA_CTRL, 32'h2);
`else
    rd_chk("ctrl_circ_bit", SDMA_CTRL, 32'h0);
`endif
    cfg_write(SDMA_CTRL, 32'h0);

    // Empty window goes straight to DONE without touching the FIFO
    cfg_write(SDMA_START, 32'h20);
    cfg_write(SDMA_END, 32'h20);
    push(16'h1234);
    acc_clear();
    rd0 = rd_cnt;
    cfg_write(SDMA_CTRL, 32'h1);
    tick(1);
    rd_chk("empty_win_status", SDMA_STATUS, 32'h0000_0002);
    chk("empty_win_no_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("empty_win_no_wr", 32'(acc_addr.size()), 32'd0);
    wr_ptr = rd_ptr;

`ifdef SAMPLE_DMA_CIRCULAR_EN
    // Ring buffer of two words, five samples
    cfg_write(SDMA_START, 32'h10);
    cfg_write(SDMA_END, 32'h12);
    for (int i = 0; i < 5; i++) push(16'hE000 + 16'(i));
    acc_clear();
    cfg_write(SDMA_CTRL, 32'h3);
    wait_acc(5, 100, "circ_wait");
    tick(2);
    for (int i = 0; i < 5 && i < acc_addr.size(); i++) begin
      chk("circ_addr", 32'(acc_addr[i]), 32'h10 + 32'(i % 2));
      chk("circ_data", 32'(acc_data[i]), 32'hE000 + 32'(i));
    end
    rd_chk("circ_status", SDMA_STATUS, 32'h0005_0005);
    rd_chk("circ_ptr", SDMA_PTR, 32'h11);
    cfg_write(SDMA_CTRL, 32'h0);
    tick(3);
`endif

    // Randomized linear runs against the word-list reference
    for (int it = 0; it < 6; it++) begin
      s     = AW'($urandom_range(0, 32'hFF_FF00));
      len   = $urandom_range(1, 8);
      n1    = $urandom_range(0, len);
      extra = $urandom_range(0, 2);
      total = len + extra;
      acc_clear();
      cfg_write(SDMA_START, 32'(s));
      cfg_write(SDMA_END, 32'(s) + 32'(len));
      for (int k = 0; k < total; k++) exp_w[k] = 16'($urandom_range(0, 16'hFFFF));
      for (int k = 0; k < n1; k++) push(exp_w[k]);
      wr_mode = 1'b1;
      cfg_write(SDMA_CTRL, 32'h1);
      tick($urandom_range(0, 20));
      for (int k = n1; k < total; k++) push(exp_w[k]);
      wait_idle(400, "rnd_wait");
      wr_mode = 1'b0;
      wready_fix = 1'b1;
      chk("rnd_nwr", 32'(acc_addr.size()), 32'(len));
      for (int k = 0; k < len && k < acc_addr.size(); k++) begin
        chk("rnd_addr", 32'(acc_addr[k]), 32'(s + AW'(k)));
        chk("rnd_data", 32'(acc_data[k]), 32'(exp_w[k]));
      end
      chk("rnd_fifo_left", 32'(wr_ptr - rd_ptr), 32'(extra));
      rd_chk("rnd_status", SDMA_STATUS, (32'(len) << 16) | 32'h2);
      rd_chk("rnd_ptr", SDMA_PTR, 32'(s + AW'(len)));
      wr_ptr = rd_ptr;
    end

    // Reset in the middle of a pending write
    cfg_write(SDMA_START, 32'h400);
    cfg_write(SDMA_END, 32'h410);
    wready_fix = 1'b0;
    push(16'hD001);
    tick(1);
    cfg_write(SDMA_CTRL, 32'h1);
    wait_wvalid(20, "rstw_wvalid");
    rst = 1'b1;
    tick(1);
    chk("rstw_wvalid", 32'(wvalid), 32'd0);
    chk("rstw_fifo_rd", 32'(fifo_rd), 32'd0);
    rst = 1'b0;
    wr_ptr = rd_ptr;
    cfg_read(SDMA_START, d, rv);
    chk("rstw_rvalid_1", 32'(rv), 32'd1);
    chk("rstw_start", d, 32'd0);
    tick(1);
    chk("rstw_rvalid_0", 32'(cfg_rvalid), 32'd0);
    rd_chk("rstw_end", SDMA_END, 32'd0);
    rd_chk("rstw_ptr", SDMA_PTR, 32'd0);
    rd_chk("rstw_ctrl", SDMA_CTRL, 32'd0);
    rd_chk("rstw_status", SDMA_STATUS, 32'd0);

    chk("wvalid_stable", 32'(stab_err), 32'd0);
    chk("rd_while_empty", 32'(rd_empty_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_dma.md
# sample_dma

Moves 16-bit compressed sample words from the sampler's clock-crossing sample FIFO into SDRAM without CPU involvement. It is the reader side of the sample FIFO: it replaces CPU polling of the FIFO data register with a streaming write engine. It sits in the `clk_48` domain between the FIFO read port and the SDRAM controller's write channel. The CPU configures it through a small register window on the IO bus.

## Interface
Parameters:
- `AW`, 24, SDRAM word-address width.

Ports:
- `clk`  in  1  `clk_48` system clock.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_rd_data`  in  16  FIFO output word, valid the cycle after `fifo_rd`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd`  out  1  FIFO read strobe, one cycle per word.
- `awaddr`  out  AW  SDRAM write word address.
- `wdata`  out  16  SDRAM write data.
- `wvalid`  out  1  write request.
- `wready`  in  1  SDRAM accepts the write when `wvalid && wready`.
- `cfg_waddr`  in  5  register byte address for writes.
- `cfg_wdata`  in  32  register write data.
- `cfg_wvalid`  in  1  register write strobe, single cycle.
- `cfg_araddr`  in  5  register byte address for reads.
- `cfg_arvalid`  in  1  register read strobe, single cycle.
- `cfg_rdata`  out  32  register read data.
- `cfg_rvalid`  out  1  read data valid.

## Operation
Registers (word-aligned byte offsets):
- 0x00 CTRL: bit0 `enable`; bit1 `circular` (only when the macro in Configuration is defined).
- 0x04 START: word address, bits [AW-1:0].
- 0x08 END: word address, exclusive, bits [AW-1:0].
- 0x0C PTR: read-only; next write address.
- 0x10 STATUS: bit0 `busy`, bit1 `done`, bit2 `wrapped`; bits [31:16] `count`, the number of words written, saturating at 0xFFFF.

Register write rules:
- START and END writes are ignored while `busy`.
- A CTRL write with `enable`=1 while idle loads PTR←START, clears `done`, `wrapped` and `count`, and enters FETCH.
- `enable`=0 requests a stop.

FSM states: IDLE, FETCH, LATCH, WRITE, DONE.
- IDLE: outputs inactive. Exits on enable as described above.
- FETCH: if END≤START, go to DONE with zero words written. If a stop is pending, go to IDLE. If `!fifo_empty`, assert `fifo_rd` for one cycle and go to LATCH. Otherwise wait.
- LATCH: capture `fifo_rd_data` into `wdata`, drive `awaddr`←PTR, raise `wvalid`, go to WRITE.
- WRITE: hold `wvalid`, `awaddr` and `wdata` stable until `wready`. On acceptance:
  - PTR+1 and `count`+1.
  - If PTR+1==END: go to DONE, or go to FETCH with PTR←START and `wrapped`←1 in circular mode.
  - Otherwise go to FETCH.
- DONE: `done`=1, `busy`=0. Stays until the next enable write. `enable` self-clears on entry.

Boundary rules:
- A stop request never drops `wvalid` before acceptance. The in-flight word completes, then the block returns to IDLE, `done` stays 0, and PTR is retained.
- Address arithmetic is AW-bit modulo. END is compared for equality only.
- A `fifo_empty` stall has no timeout and does not lose data.
- `cfg_wvalid` and `cfg_arvalid` in the same cycle: the read returns the pre-write value.
- A read of an unmapped offset returns 0.

## Timing
- Reset values: `fifo_rd`=0, `wvalid`=0, `awaddr`=0, `wdata`=0, `cfg_rvalid`=0, `cfg_rdata`=0. All registers are 0 and the FSM is in IDLE.
- Reset mid-write drops `wvalid` the next cycle. This is legal because the SDRAM controller is reset in the same system reset.
- `cfg_rvalid` rises exactly 1 cycle after `cfg_arvalid`, for 1 cycle.
- Enable write at cycle 0 → FETCH at cycle 1.
- Non-empty FIFO: `fifo_rd` at t, `wvalid` at t+2.
- Minimum per-word period is 3 cycles plus `wready` wait cycles.
- `fifo_rd` is never asserted while `fifo_empty`=1.

## Configuration
`SAMPLE_DMA_CIRCULAR_EN`:
- Defined: CTRL bit1 is implemented, and ring-buffer wrap and `wrapped` are active.
- Undefined: CTRL bit1 reads 0 and writes to it are ignored, `wrapped` is always 0, and reaching END always enters DONE.

## Structure
- A shared package `sample_dma_pkg` holds:
  - the register offset constants (`SDMA_CTRL`, `SDMA_START`, `SDMA_END`, `SDMA_PTR`, `SDMA_STATUS`);
  - the FSM state enum;
  - the STATUS bit positions.
- A single module; no sub-module is warranted. The register file and FSM are two always blocks in the same file.

## Test plan
- START=0x000100, END=0x000104, FIFO preloaded with 0xA001..0xA004, `wready` tied 1 → four writes to 0x100..0x103 with matching data; DONE with STATUS=0x0004_0002; PTR=0x104.
- `wready` held low for 5 cycles on the second word → `wvalid`, `awaddr` and `wdata` stable throughout; accepted exactly once; `count`=2 afterwards.
- Circular mode (macro defined), START=0x10, END=0x12, 5 words → addresses 0x10, 0x11, 0x10, 0x11, 0x10; `wrapped`=1, `busy`=1.
- `enable` cleared while `wvalid` is pending with `wready`=0 → the write completes when `wready` rises, then IDLE; `done`=0; PTR = last address+1.
- END=START=0x20 with enable → DONE within 2 cycles, no `fifo_rd`, no `wvalid`.
- `rst` asserted during WRITE → next cycle `wvalid`=0, `fifo_rd`=0, all registers read 0, and reads return `cfg_rvalid` 1 cycle after `cfg_arvalid`.
